// File: rtl/strobe_frame_rx_if.sv
// Word output handshake between strobe_frame_rx and its consumer.
interface strobe_frame_rx_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/strobe_frame_rx.sv
// Strobe-qualified serial-to-word receiver: MSB-first words grouped into frames,
// followed by a guard gap and a closing strobe; words leave on a valid/ready port.
module strobe_frame_rx #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned GAP    = 2,
  localparam int unsigned BW    = (DATA_W > 1) ? $clog2(DATA_W) : 1,
  localparam int unsigned WW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          strobe,
  input  logic          din,
  input  logic          abort,
  input  logic          clear_err,
  strobe_frame_rx_if.master out_if,
  output logic          active,
  output logic [BW-1:0] bitno,
  output logic [WW-1:0] wordno,
  output logic          frame_done,
  output logic          overrun
);

  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [BW-1:0] BitLast  = BW'(DATA_W - 1);
  localparam logic [WW-1:0] WordLast = WW'(WORDS - 1);
  localparam logic [GW-1:0] GapLoad  = GW'(GAP - 1);

  typedef enum logic [1:0] {StIdle, StShift, StGap, StClose} state_e;

  state_e              r_state, w_state_d;
  logic [BW-1:0]       r_bitno, w_bitno_d;
  logic [WW-1:0]       r_wordno, w_wordno_d;
  logic [DATA_W-1:0]   r_shift, w_shift_d;
  logic [GW-1:0]       r_gap, w_gap_d;
  logic [DATA_W-1:0]   r_out_data, w_out_data_d;
  logic                r_out_valid, w_out_valid_d;
  logic                r_frame_done, w_frame_done_d;
  logic                r_overrun, w_overrun_d;

  logic [DATA_W-1:0]   w_shift_in;
  logic                w_word_done;
  logic                w_frame_end;
  logic                w_xfer;
  logic                w_drop;

  // Truncating cast keeps the low DATA_W bits; also covers DATA_W == 1.
  assign w_shift_in = DATA_W'({r_shift, din});

  always_comb begin
    w_state_d   = r_state;
    w_bitno_d   = r_bitno;
    w_wordno_d  = r_wordno;
    w_shift_d   = r_shift;
    w_gap_d     = r_gap;
    w_word_done = 1'b0;
    w_frame_end = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (strobe) w_state_d = StShift;
      end
      StShift: begin
        if (strobe) begin
          w_shift_d = w_shift_in;
          if (r_bitno == BitLast) begin
            w_word_done = 1'b1;
            w_bitno_d   = '0;
            if (r_wordno == WordLast) begin
              w_wordno_d  = '0;
              w_frame_end = 1'b1;
              w_gap_d     = GapLoad;
              w_state_d   = StGap;
            end else begin
              w_wordno_d = r_wordno + WW'(1);
            end
          end else begin
            w_bitno_d = r_bitno + BW'(1);
          end
        end
      end
      StGap: begin
        if (r_gap == '0) w_state_d = StClose;
        else             w_gap_d   = r_gap - GW'(1);
      end
      StClose: begin
        if (strobe) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

    // Abort outranks any strobe activity in the same cycle.
    if (abort && (r_state != StIdle)) begin
      w_state_d   = StIdle;
      w_bitno_d   = '0;
      w_wordno_d  = '0;
      w_shift_d   = '0;
      w_gap_d     = '0;
      w_word_done = 1'b0;
      w_frame_end = 1'b0;
    end
  end

  assign w_xfer = r_out_valid & out_if.out_ready;
  assign w_drop = w_word_done & r_out_valid & ~out_if.out_ready;

  always_comb begin
    w_out_valid_d  = r_out_valid;
    w_out_data_d   = r_out_data;
    w_frame_done_d = w_frame_end;
    if (w_word_done) begin
      w_out_valid_d = 1'b1;
      if (!w_drop) w_out_data_d = w_shift_in;
    end else if (w_xfer) begin
      w_out_valid_d = 1'b0;
    end
    // Set wins over clear.
    w_overrun_d = w_drop | (r_overrun & ~clear_err);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= StIdle;
      r_bitno      <= '0;
      r_wordno     <= '0;
      r_shift      <= '0;
      r_gap        <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_bitno      <= w_bitno_d;
      r_wordno     <= w_wordno_d;
      r_shift      <= w_shift_d;
      r_gap        <= w_gap_d;
      r_out_data   <= w_out_data_d;
      r_out_valid  <= w_out_valid_d;
      r_frame_done <= w_frame_done_d;
      r_overrun    <= w_overrun_d;
    end
  end

  assign active           = (r_state == StIdle) || (r_state == StShift);
  assign bitno            = r_bitno;
  assign wordno           = r_wordno;
  assign frame_done       = r_frame_done;
  assign overrun          = r_overrun;
  assign out_if.out_data  = r_out_data;
  assign out_if.out_valid = r_out_valid;

endmodule

// File: tb/tb_strobe_frame_rx.sv
// Directed bench for strobe_frame_rx: an 8x2/gap-2 instance and a 5x3/gap-1 instance.
module tb_strobe_frame_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       a_strobe, a_din, a_abort, a_clear;
  logic       a_active, a_frame_done, a_overrun;
  logic [2:0] a_bitno;
  logic [0:0] a_wordno;
  strobe_frame_rx_if #(.DATA_W(8)) a_if ();

  strobe_frame_rx #(.DATA_W(8), .WORDS(2), .GAP(2)) u_dut_a (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .strobe     (a_strobe),
    .din        (a_din),
    .abort      (a_abort),
    .clear_err  (a_clear),
    .out_if     (a_if.master),
    .active     (a_active),
    .bitno      (a_bitno),
    .wordno     (a_wordno),
    .frame_done (a_frame_done),
    .overrun    (a_overrun)
  );

  logic       b_strobe, b_din, b_abort, b_clear;
  logic       b_active, b_frame_done, b_overrun;
  logic [2:0] b_bitno;
  logic [1:0] b_wordno;
  strobe_frame_rx_if #(.DATA_W(5)) b_if ();

  strobe_frame_rx #(.DATA_W(5), .WORDS(3), .GAP(1)) u_dut_b (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .strobe     (b_strobe),
    .din        (b_din),
    .abort      (b_abort),
    .clear_err  (b_clear),
    .out_if     (b_if.master),
    .active     (b_active),
    .bitno      (b_bitno),
    .wordno     (b_wordno),
    .frame_done (b_frame_done),
    .overrun    (b_overrun)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Drive one cycle of inputs, then settle #1 past the sampling edge.
  task automatic cyc_a(input logic s, input logic d);
    a_strobe = s;
    a_din    = d;
    @(posedge clk);
    #1;
    a_strobe = 1'b0;
  endtask

  task automatic cyc_b(input logic s, input logic d);
    b_strobe = s;
    b_din    = d;
    @(posedge clk);
    #1;
    b_strobe = 1'b0;
  endtask

  task automatic a_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) cyc_a(1'b1, w[i]);
  endtask

  task automatic b_word(input logic [4:0] w);
    for (int i = 4; i >= 0; i--) cyc_b(1'b1, w[i]);
  endtask

  // From the first GAP cycle: one more GAP cycle, CLOSE, then a closing strobe.
  task automatic a_finish(input string tag);
    cyc_a(1'b0, 1'b0);
    cyc_a(1'b0, 1'b0);
    cyc_a(1'b1, 1'b0);
    check({tag, "_idle_active"}, a_active, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    a_strobe = 0; a_din = 0; a_abort = 0; a_clear = 0; a_if.out_ready = 1'b0;
    b_strobe = 0; b_din = 0; b_abort = 0; b_clear = 0; b_if.out_ready = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_active", a_active, 1);
    check("rst_bitno", a_bitno, 0);
    check("rst_wordno", a_wordno, 0);
    check("rst_data", a_if.out_data, 0);
    check("rst_valid", a_if.out_valid, 0);
    check("rst_fdone", a_frame_done, 0);
    check("rst_ovr", a_overrun, 0);

    // Basic frame with consumer always ready
    a_if.out_ready = 1'b1;
    cyc_a(1'b1, 1'b1);
    check("t1_start_bitno", a_bitno, 0);
    a_word(8'hA5);
    check("t1_w0_data", a_if.out_data, 8'hA5);
    check("t1_w0_valid", a_if.out_valid, 1);
    check("t1_w0_fdone", a_frame_done, 0);
    check("t1_w0_wordno", a_wordno, 1);
    check("t1_w0_bitno", a_bitno, 0);
    for (int i = 7; i >= 0; i--) begin
      cyc_a(1'b1, logic'((8'h3C >> i) & 8'h01));
      if (i == 7) check("t1_w0_one_cycle", a_if.out_valid, 0);
    end
    check("t1_w1_data", a_if.out_data, 8'h3C);
    check("t1_w1_valid", a_if.out_valid, 1);
    check("t1_w1_fdone", a_frame_done, 1);
    check("t1_gap0_active", a_active, 0);
    check("t1_w1_wordno", a_wordno, 0);
    cyc_a(1'b1, 1'b1);  // strobe in GAP is ignored
    check("t1_gap1_active", a_active, 0);
    check("t1_fdone_pulse", a_frame_done, 0);
    check("t1_w1_one_cycle", a_if.out_valid, 0);
    cyc_a(1'b1, 1'b1);  // strobe in last GAP cycle: still ignored, moves to CLOSE
    check("t1_close_active", a_active, 0);
    cyc_a(1'b0, 1'b0);
    check("t1_close_hold", a_active, 0);
    cyc_a(1'b1, 1'b0);
    check("t1_idle_active", a_active, 1);
    check("t1_idle_bitno", a_bitno, 0);
    check("t1_idle_wordno", a_wordno, 0);

    // Consumer stalled: second word is dropped
    a_if.out_ready = 1'b0;
    cyc_a(1'b1, 1'b0);
    a_word(8'hA5);
    check("t2_w0_data", a_if.out_data, 8'hA5);
    a_word(8'h3C);
    check("t2_drop_data", a_if.out_data, 8'hA5);
    check("t2_drop_valid", a_if.out_valid, 1);
    check("t2_ovr_set", a_overrun, 1);
    check("t2_fdone", a_frame_done, 1);
    a_clear = 1'b1;
    cyc_a(1'b0, 1'b0);
    a_clear = 1'b0;
    check("t2_ovr_clr", a_overrun, 0);
    check("t2_valid_kept", a_if.out_valid, 1);
    cyc_a(1'b0, 1'b0);
    cyc_a(1'b1, 1'b0);
    check("t2_idle_active", a_active, 1);
    a_if.out_ready = 1'b1;
    cyc_a(1'b0, 1'b0);
    check("t2_drained", a_if.out_valid, 0);

    // Completion coincides with acceptance of the previous word
    a_if.out_ready = 1'b0;
    cyc_a(1'b1, 1'b0);
    a_word(8'hA5);
    for (int i = 7; i >= 1; i--) cyc_a(1'b1, logic'((8'h3C >> i) & 8'h01));
    a_if.out_ready = 1'b1;
    cyc_a(1'b1, 1'b0);
    check("t3_data", a_if.out_data, 8'h3C);
    check("t3_valid", a_if.out_valid, 1);
    check("t3_ovr", a_overrun, 0);
    a_finish("t3");
    check("t3_drained", a_if.out_valid, 0);

    // Abort mid-word, then a clean restart
    cyc_a(1'b1, 1'b0);
    cyc_a(1'b1, 1'b1); cyc_a(1'b1, 1'b0); cyc_a(1'b1, 1'b1);
    cyc_a(1'b1, 1'b1); cyc_a(1'b1, 1'b0);
    check("t4_pre_bitno", a_bitno, 5);
    a_abort = 1'b1;
    cyc_a(1'b1, 1'b1);
    a_abort = 1'b0;
    check("t4_abort_active", a_active, 1);
    check("t4_abort_bitno", a_bitno, 0);
    check("t4_abort_valid", a_if.out_valid, 0);
    cyc_a(1'b1, 1'b1);  // start marker, din ignored
    check("t4_restart_bitno", a_bitno, 0);
    a_word(8'hFF);
    check("t4_w0_data", a_if.out_data, 8'hFF);
    check("t4_w0_wordno", a_wordno, 1);
    a_word(8'h00);
    check("t4_w1_data", a_if.out_data, 8'h00);
    check("t4_w1_valid", a_if.out_valid, 1);
    check("t4_w1_fdone", a_frame_done, 1);
    a_finish("t4");

    // Asynchronous reset mid-SHIFT with a word pending
    a_if.out_ready = 1'b0;
    cyc_a(1'b1, 1'b0);
    a_word(8'hA5);
    cyc_a(1'b1, 1'b1); cyc_a(1'b1, 1'b1); cyc_a(1'b1, 1'b0);
    check("t5_pre_bitno", a_bitno, 3);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", a_if.out_valid, 0);
    check("t5_rst_data", a_if.out_data, 0);
    check("t5_rst_bitno", a_bitno, 0);
    check("t5_rst_active", a_active, 1);
    #1 rst_n = 1'b1;
    a_if.out_ready = 1'b1;

    // Non-power-of-2 instance
    b_if.out_ready = 1'b1;
    cyc_b(1'b1, 1'b0);
    for (int i = 4; i >= 1; i--) cyc_b(1'b1, logic'((5'h1F >> i) & 5'h01));
    check("t6_bitno_max", b_bitno, 4);
    cyc_b(1'b1, 1'b1);
    check("t6_bitno_wrap", b_bitno, 0);
    check("t6_w0_data", b_if.out_data, 5'h1F);
    check("t6_w0_wordno", b_wordno, 1);
    b_word(5'h0A);
    check("t6_w1_data", b_if.out_data, 5'h0A);
    check("t6_wordno_max", b_wordno, 2);
    b_word(5'h15);
    check("t6_w2_data", b_if.out_data, 5'h15);
    check("t6_wordno_wrap", b_wordno, 0);
    check("t6_fdone", b_frame_done, 1);
    check("t6_gap_active", b_active, 0);
    cyc_b(1'b0, 1'b0);
    check("t6_close_active", b_active, 0);
    cyc_b(1'b1, 1'b0);
    check("t6_idle_active", b_active, 1);
    check("t6_ovr", b_overrun, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
